intr_ctrl: RTL

Interrupt controller for the OTTER MCU that sits directly upstream of the CSR block. It synchronizes up to NUM_SRC asynchronous interrupt lines, latches rising edges as pending bits, applies a software mask, and gates the result with mstatus.MIE. It drives the single INTR request to the control FSM. The FSM's INT_TAKEN pulse is fed to both this block and the CSR. This block clears the serviced pending bit, exposes the cause index, and holds off further requests until MRET executes.

---
 rtl/intr_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-latched, maskable interrupt controller feeding the OTTER control FSM.
//
// Ports:
//   CLK         system clock, all state on its rising edge
//   RST         synchronous active-high reset
//   IRQ_IN      asynchronous interrupt lines (index 0 = highest priority)
//   MIE         mstatus.MIE from the CSR block (only combinational input path)
//   INT_TAKEN   trap-entry pulse from the control FSM
//   mret_exec   MRET retire pulse
//   MASK_WE     mask write strobe
//   MASK_WD     mask write data, 1 = source enabled
//   INTR        interrupt request to the control FSM
//   CAUSE       index of highest-priority enabled pending source (0 if none)
//   PENDING     raw pending bits, unmasked
//   IN_SERVICE  high from trap entry until MRET
//
// Build option: define INTR_LEVEL_EN for level-sensitive sources (pending is
// the synchronized line level; nothing is latched or cleared by INT_TAKEN).
module intr_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic               MIE,
    input  logic               INT_TAKEN,
    input  logic               mret_exec,
    input  logic               MASK_WE,
    input  logic [NUM_SRC-1:0] MASK_WD,
    output logic               INTR,
    output logic [3:0]         CAUSE,
    output logic [NUM_SRC-1:0] PENDING,
    output logic               IN_SERVICE
);
    typedef enum logic {IDLE, SERVICE} state_t;
    state_t state, state_nxt;
    logic [NUM_SRC-1:0] sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] level;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] req;
    logic take;
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync[s] <= '0;
        end else begin
            sync[0] <= IRQ_IN;
            for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
        end
    end
    assign level = sync[SYNC_STAGES-1];
`ifdef INTR_LEVEL_EN
    assign PENDING = level;
`else
    logic [NUM_SRC-1:0] hist;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    assign rise = level & ~hist;
    assign clr  = take ? (NUM_SRC'(1) << CAUSE) : '0;
    // OR-ing rise after the clear makes a coincident new edge win over the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hist    <= '0;
            PENDING <= '0;
        end else begin
            hist    <= level;
            PENDING <= (PENDING & ~clr) | rise;
        end
    end
`endif
    always_ff @(posedge CLK) begin
        if (RST) mask <= '1;
        else if (MASK_WE) mask <= MASK_WD;
    end
    assign req = PENDING & mask;
    always_comb begin
        CAUSE = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) if (req[i]) CAUSE = 4'(i);
    end
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_nxt;
    end
    // INT_TAKEN only counts when a request was actually presented; in SERVICE
    // only mret_exec matters, so simultaneous pulses resolve by state.
    always_comb begin
        state_nxt  = state;
        INTR       = 1'b0;
        IN_SERVICE = 1'b0;
        take       = 1'b0;
        unique case (state)
            IDLE: begin
                INTR = (|req) & MIE;
                take = INT_TAKEN & INTR;
                state_nxt = take ? SERVICE : IDLE;
            end
            SERVICE: begin
                IN_SERVICE = 1'b1;
                state_nxt = mret_exec ? IDLE : SERVICE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
